// File: rtl/wb_master_cmd_if.sv
// Wishbone B3 classic bus bundle shared by the command master and its slaves.
interface wishbone_b3 #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int SELECT_WIDTH = 4
);
    logic                    cyc;
    logic                    stb;
    logic                    we;
    logic [ADDR_WIDTH-1:0]   adr;
    logic [SELECT_WIDTH-1:0] sel;
    logic [DATA_WIDTH-1:0]   dat_m2s;
    logic [DATA_WIDTH-1:0]   dat_s2m;
    logic                    ack;
    logic                    err;
    logic                    rty;

    modport master (output cyc, stb, we, adr, sel, dat_m2s,
                    input  ack, err, rty, dat_s2m);
    modport slave  (input  cyc, stb, we, adr, sel, dat_m2s,
                    output ack, err, rty, dat_s2m);
endinterface

// File: rtl/wb_master_cmd.sv
// Single-outstanding Wishbone B3 master: one command in, one bus transfer
// with bounded retries and per-attempt timeout, one response pulse out.
module wb_master_cmd #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int SELECT_WIDTH = 4,
    parameter int TIMEOUT      = 16,
    parameter int MAX_RETRY    = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    wishbone_b3.master              bus,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_we,
    input  logic [ADDR_WIDTH-1:0]   cmd_adr,
    input  logic [DATA_WIDTH-1:0]   cmd_dat,
    input  logic [SELECT_WIDTH-1:0] cmd_sel,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_dat,
    output logic [1:0]              rsp_status
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [1:0] ST_OK    = 2'd0;
    localparam logic [1:0] ST_ERR   = 2'd1;
    localparam logic [1:0] ST_TMO   = 2'd2;
    localparam logic [1:0] ST_RTYX  = 2'd3;

    typedef enum logic [1:0] {IDLE, BUS, BACKOFF, RESP} state_t;

    state_t                  state_q, state_d;
    logic                    cyc_q, cyc_d;
    logic                    stb_q, stb_d;
    logic                    we_q, we_d;
    logic                    cmd_we_q, cmd_we_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [SELECT_WIDTH-1:0] sel_q, sel_d;
    logic [DATA_WIDTH-1:0]   dat_q, dat_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic [RW-1:0]           retry_q, retry_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_dat_q, rsp_dat_d;
    logic [1:0]              rsp_status_q, rsp_status_d;

    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        stb_d        = stb_q;
        we_d         = we_q;
        cmd_we_d     = cmd_we_q;
        adr_d        = adr_q;
        sel_d        = sel_q;
        dat_d        = dat_q;
        timer_d      = timer_q;
        retry_d      = retry_q;
        rsp_valid_d  = 1'b0;
        rsp_dat_d    = rsp_dat_q;
        rsp_status_d = rsp_status_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    cmd_we_d = cmd_we;
                    adr_d    = cmd_adr;
                    sel_d    = cmd_sel;
                    dat_d    = cmd_dat;
                    timer_d  = '0;
                    retry_d  = '0;
                    cyc_d    = 1'b1;
                    stb_d    = 1'b1;
                    we_d     = cmd_we;
                    state_d  = BUS;
                end
            end
            BUS: begin
                // err wins over ack, ack wins over rty when sampled together
                if (bus.err || bus.ack || bus.rty ||
                    timer_q == TW'(TIMEOUT - 1)) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = '0;
                    if (bus.err) begin
                        rsp_status_d = ST_ERR;
                    end else if (bus.ack) begin
                        rsp_status_d = ST_OK;
                        if (!cmd_we_q) rsp_dat_d = bus.dat_s2m;
                    end else if (bus.rty) begin
                        if (retry_q < RW'(MAX_RETRY)) begin
                            retry_d     = retry_q + RW'(1);
                            state_d     = BACKOFF;
                            rsp_valid_d = 1'b0;
                            rsp_dat_d   = rsp_dat_q;
                        end else begin
                            rsp_status_d = ST_RTYX;
                        end
                    end else begin
                        rsp_status_d = ST_TMO;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            BACKOFF: begin
                timer_d = '0;
                cyc_d   = 1'b1;
                stb_d   = 1'b1;
                we_d    = cmd_we_q;
                state_d = BUS;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            we_q         <= 1'b0;
            cmd_we_q     <= 1'b0;
            adr_q        <= '0;
            sel_q        <= '0;
            dat_q        <= '0;
            timer_q      <= '0;
            retry_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_dat_q    <= '0;
            rsp_status_q <= 2'd0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            stb_q        <= stb_d;
            we_q         <= we_d;
            cmd_we_q     <= cmd_we_d;
            adr_q        <= adr_d;
            sel_q        <= sel_d;
            dat_q        <= dat_d;
            timer_q      <= timer_d;
            retry_q      <= retry_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_dat_q    <= rsp_dat_d;
            rsp_status_q <= rsp_status_d;
        end
    end

    assign cmd_ready   = (state_q == IDLE) && !reset;
    assign bus.cyc     = cyc_q;
    assign bus.stb     = stb_q;
    assign bus.we      = we_q;
    assign bus.adr     = adr_q;
    assign bus.sel     = sel_q;
    assign bus.dat_m2s = dat_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_dat     = rsp_dat_q;
    assign rsp_status  = rsp_status_q;
endmodule

// File: tb/tb_wb_master_cmd.sv
// Directed bench for wb_master_cmd: scripted Wishbone slave plus response scoreboard.
module tb_wb_master_cmd;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid;
    logic [31:0] rsp_dat;
    logic [1:0]  rsp_status;

    typedef struct {
        logic [1:0]  st;
        logic [31:0] dat;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // slave behaviour: 0 ack, 1 silent, 2 rty s_rty_n times then ack, 3 always rty, 4 err+ack
    int          s_mode = 0;
    int          s_rty_n = 0;
    int          s_idx;
    logic [31:0] mem [16];

    wishbone_b3 #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SELECT_WIDTH(4)) bus_if ();

    wb_master_cmd #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .SELECT_WIDTH(4),
        .TIMEOUT(16), .MAX_RETRY(3)
    ) dut (
        .clk(clk), .reset(rst), .bus(bus_if.master),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_dat(rsp_dat), .rsp_status(rsp_status)
    );

    always #5 clk = ~clk;

    always_comb begin
        bus_if.ack     = 1'b0;
        bus_if.err     = 1'b0;
        bus_if.rty     = 1'b0;
        bus_if.dat_s2m = (s_mode == 4) ? 32'hDEAD_BEEF : mem[bus_if.adr[5:2]];
        if (bus_if.cyc && bus_if.stb) begin
            bus_if.ack = (s_mode == 0) || (s_mode == 4) || (s_mode == 2 && s_idx >= s_rty_n);
            bus_if.rty = (s_mode == 3) || (s_mode == 2 && s_idx < s_rty_n);
            bus_if.err = (s_mode == 4);
        end
    end

    always @(posedge clk) begin
        if (cmd_valid && cmd_ready) s_idx <= 0;
        else if (bus_if.cyc && bus_if.stb && bus_if.rty) s_idx <= s_idx + 1;
        if (bus_if.cyc && bus_if.stb && bus_if.we && bus_if.ack && !bus_if.err)
            mem[bus_if.adr[5:2]] <= bus_if.dat_m2s;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_cmd(input string tag, input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel,
                          input int mode, input int rn,
                          input logic [1:0] est, input logic [31:0] edat,
                          input int elat, input int ecyc, input int eatt);
        exp_t e;
        int   ncyc = 0;
        int   natt = 0;
        int   lat  = 0;
        logic pc   = 1'b0;
        s_mode  = mode;
        s_rty_n = rn;
        sb.push_back('{st: est, dat: edat});
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        #1 chk({tag, "_ready"}, cmd_ready, 1'b1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (bus_if.cyc) begin
                ncyc++;
                if (!pc) natt++;
                chk({tag, "_bus"}, {bus_if.stb, bus_if.we, bus_if.sel, bus_if.adr, bus_if.dat_m2s},
                    {1'b1, we, sel, adr, dat});
            end else begin
                chk({tag, "_idle_stb_we"}, {bus_if.stb, bus_if.we}, 2'b00);
            end
            pc = bus_if.cyc;
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
        chk({tag, "_rsp_seen"}, (lat != 0), 1'b1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_status"}, rsp_status, e.st);
            chk({tag, "_rdat"}, rsp_dat, e.dat);
        end
        chk({tag, "_latency"}, lat, elat);
        chk({tag, "_cyc_cycles"}, ncyc, ecyc);
        chk({tag, "_attempts"}, natt, eatt);
        @(negedge clk);
        chk({tag, "_pulse_one"}, {rsp_valid, cmd_ready}, 2'b01);
        chk({tag, "_hold"}, {rsp_status, rsp_dat}, {est, edat});
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
        repeat (2) @(negedge clk);
        chk("reset_outs", {bus_if.cyc, bus_if.stb, bus_if.we, cmd_ready, rsp_valid, rsp_status},
            6'b0);
        chk("reset_data", {bus_if.adr, bus_if.sel, bus_if.dat_m2s, rsp_dat}, 100'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", cmd_ready, 1'b1);

        do_cmd("wr_ack",    1'b1, 32'h0, 32'h1234_5678, 4'hF, 0, 0, 2'd0, 32'h0,          2, 1, 1);
        do_cmd("rd_ack",    1'b0, 32'h0, 32'h0,         4'hF, 0, 0, 2'd0, 32'h1234_5678,  2, 1, 1);
        do_cmd("wr_ack2",   1'b1, 32'h4, 32'hA5A5_0001, 4'h3, 0, 0, 2'd0, 32'h0,          2, 1, 1);
        do_cmd("rd_ack2",   1'b0, 32'h4, 32'h0,         4'h3, 0, 0, 2'd0, 32'hA5A5_0001,  2, 1, 1);
        do_cmd("rd_tmo",    1'b0, 32'h0, 32'h0,         4'hF, 1, 0, 2'd2, 32'h0,         17, 16, 1);
        do_cmd("wr_rty2",   1'b1, 32'h8, 32'hCAFE_F00D, 4'hF, 2, 2, 2'd0, 32'h0,          6, 3, 3);
        do_cmd("rd_rty2",   1'b0, 32'h8, 32'h0,         4'hF, 2, 2, 2'd0, 32'hCAFE_F00D,  6, 3, 3);
        do_cmd("wr_rtyx",   1'b1, 32'hC, 32'h5555_AAAA, 4'h1, 3, 0, 2'd3, 32'h0,          8, 4, 4);
        do_cmd("rd_ack3",   1'b0, 32'h4, 32'h0,         4'hF, 0, 0, 2'd0, 32'hA5A5_0001,  2, 1, 1);
        do_cmd("rd_errack", 1'b0, 32'h4, 32'h0,         4'hF, 4, 0, 2'd1, 32'h0,          2, 1, 1);

        // abort a silent transfer with reset while the bus is active
        s_mode = 1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h10; cmd_dat = 32'h7777_0000; cmd_sel = 4'hF;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_cyc_before", bus_if.cyc, 1'b1);
        rst = 1'b1;
        #1 chk("abort_bus_low", {bus_if.cyc, bus_if.stb, bus_if.we, cmd_ready, rsp_valid}, 5'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_rsp", {rsp_valid, bus_if.cyc}, 2'b00);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", {cmd_ready, rsp_valid, rsp_status}, 4'b1000);
        chk("abort_rdat", rsp_dat, 32'h0);

        do_cmd("rd_post_rst", 1'b0, 32'h8, 32'h0, 4'hF, 0, 0, 2'd0, 32'hCAFE_F00D, 2, 1, 1);
        do_cmd("wr_tmo",      1'b1, 32'h0, 32'h0BAD_0BAD, 4'hF, 1, 0, 2'd2, 32'h0, 17, 16, 1);
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
